// File: rtl/sm_run_ctrl_pkg.sv
// sm_run_ctrl_pkg: shared FSM states, command codes and instruction fields
package sm_run_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2, S_HALT = 3'd3, S_CLR = 3'd4} state_t;
  typedef enum logic [1:0] {CMD_RUN = 2'd0, CMD_STEP = 2'd1, CMD_HALT = 2'd2, CMD_CLR = 2'd3} cmd_t;
  localparam int INST_W = 12;
  localparam int OP_MSB = 11;
  localparam int OP_LSB = 8;
  localparam int VAL_MSB = 7;
  localparam int VAL_LSB = 0;
  localparam logic [3:0] OP_0 = 4'h0;
  localparam logic [3:0] OP_1 = 4'h1;
  localparam logic [3:0] OP_2 = 4'h2;
  localparam logic [3:0] OP_3 = 4'h3;
  localparam logic [3:0] OP_4 = 4'h4;
  localparam logic [3:0] OP_5 = 4'h5;
  localparam logic [3:0] OP_6 = 4'h6;
  localparam logic [3:0] OP_7 = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;
  function automatic logic [3:0] inst_op(input logic [INST_W-1:0] i);
    return i[OP_MSB:OP_LSB];
  endfunction
endpackage

// File: rtl/sm_inst_ram.sv
// sm_inst_ram: instruction store with one write port and an asynchronous read port
module sm_inst_ram
  import sm_run_ctrl_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);
  logic [INST_W-1:0] r_mem [DEPTH];
  assign rdata = r_mem[raddr];
  // contents survive reset on purpose, so there is no reset branch
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end
endmodule

// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: run/step/halt/clear controller for a stack-machine core
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter int INST_DEPTH = 32,
  parameter int CYC_W = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              host_we,
  input  logic [4:0]        host_addr,
  input  logic [INST_W-1:0] host_wdata,
  output logic              wr_err,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  output logic              cmd_ready,
  input  logic              bp_en,
  input  logic [4:0]        bp_addr,
  input  logic [4:0]        core_pc,
  output logic [INST_W-1:0] inst_out,
  output logic              core_en,
  output logic              core_rstN,
  output logic [2:0]        state,
  output logic              halted,
  output logic [CYC_W-1:0]  cyc_cnt
);
  state_t           r_state;
  state_t           w_next;
  logic             r_clr;
  logic             r_wr_err;
  logic [CYC_W-1:0] r_cyc_cnt;
  logic             w_wr_ok;
  logic             w_stop;
  cmd_t             w_cmd;
  sm_inst_ram #(.DEPTH(INST_DEPTH), .AW(5)) u_ram (
    .clk  (clk),
    .we   (host_we && w_wr_ok),
    .waddr(host_addr),
    .wdata(host_wdata),
    .raddr(core_pc),
    .rdata(inst_out)
  );
  assign w_cmd     = cmd_t'(cmd);
  assign w_wr_ok   = r_state == S_IDLE || r_state == S_HALT;
  assign w_stop    = (bp_en && core_pc == bp_addr) || inst_op(inst_out) == OP_HALT;
  assign core_rstN = rstN && r_state != S_CLR;
  assign state     = r_state;
  assign halted    = r_state == S_HALT;
  assign wr_err    = r_wr_err;
  assign cyc_cnt   = r_cyc_cnt;
  // next state, command handshake and core enable
  always_comb begin
    w_next = r_state;
    cmd_ready = 1'b0;
    core_en = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = w_cmd == CMD_RUN ? S_RUN : w_cmd == CMD_STEP ? S_STEP : w_cmd == CMD_CLR ? S_CLR : r_state;
      end
      S_RUN: begin
        cmd_ready = w_cmd == CMD_HALT;
        core_en = !w_stop;
        if (w_stop || (cmd_valid && w_cmd == CMD_HALT)) w_next = S_HALT;
      end
      S_STEP: begin
        core_en = 1'b1;
        w_next = S_HALT;
      end
      S_CLR: w_next = r_clr ? S_IDLE : S_CLR;
      default: w_next = S_IDLE;
    endcase
  end
  // state register, two-cycle clear timer, write-reject pulse and saturating cycle counter
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
      r_clr <= 1'b0;
      r_wr_err <= 1'b0;
      r_cyc_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_clr <= r_state == S_CLR && !r_clr;
      r_wr_err <= host_we && !w_wr_ok;
      r_cyc_cnt <= r_state == S_CLR ? '0 : (core_en && !(&r_cyc_cnt)) ? r_cyc_cnt + 1'b1 : r_cyc_cnt;
    end
  end
endmodule
